// File: rtl/lidar_bitstream_pkg.sv
// Shared types and constants for the LiDAR decoder bitstream read path.
package lidar_bitstream_pkg;

    localparam int WORD_W = 512;
    localparam int MAX_RD = 32;
    localparam int CNT_W  = 32;
    localparam int WIN_W  = 2 * WORD_W;

    typedef logic [WORD_W-1:0] bs_word_t;
    typedef logic [5:0]        rd_len_t;
    typedef logic [8:0]        ptr_t;

    // A read length is usable only in the range 1..MAX_RD.
    function automatic logic rd_len_legal(input rd_len_t len);
        return (len != 6'd0) && (len <= 6'(MAX_RD));
    endfunction

endpackage

// File: rtl/bit_window_extract.sv
// Combinational barrel extract: takes up to 32 bits MSB-first from the
// 1024-bit window {cur_word, nxt_word}, starting ptr bits below bit 1023,
// and returns them right-justified and zero-extended.
module bit_window_extract
    import lidar_bitstream_pkg::*;
(
    input  bs_word_t    cur_word,
    input  bs_word_t    nxt_word,
    input  ptr_t        ptr,
    input  rd_len_t     rd_len,
    output logic [31:0] data
);

    logic [WIN_W-1:0] window;
    logic [WIN_W-1:0] shifted;
    logic [31:0]      top_bits;
    logic [5:0]       shamt;

    // Left-align the unread bits, take the top 32, then drop the excess low bits.
    always_comb begin
        window   = {cur_word, nxt_word};
        shifted  = window << ptr;
        top_bits = shifted[WIN_W-1 -: 32];
        shamt    = 6'd32 - rd_len;
        data     = top_bits >> shamt;
    end

endmodule

// File: rtl/bitstream_bit_reader.sv
// Two-word bitstream window feeding MSB-first 1..32-bit field reads to the
// syntax parser. The current word is consumed from bit 511 downwards; once a
// read crosses the end of it, the next word is promoted so reads can straddle
// word boundaries. The word input never depends on the same-cycle read, which
// keeps rd_req off the word_ready path.
module bitstream_bit_reader
    import lidar_bitstream_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        word_valid,
    input  logic [511:0] word_data,
    output logic        word_ready,
    input  logic        rd_req,
    input  logic [5:0]  rd_len,
    output logic        rd_ready,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        rd_err,
    output logic [10:0] bits_avail,
    output logic [31:0] bit_count
);

    bs_word_t    cur_q, cur_d;
    bs_word_t    nxt_q, nxt_d;
    logic        cur_v_q, cur_v_d;
    logic        nxt_v_q, nxt_v_d;
    ptr_t        ptr_q, ptr_d;
    logic        rd_valid_q, rd_valid_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_err_q, rd_err_d;
    logic [CNT_W-1:0] bit_count_q, bit_count_d;

    logic        len_ok;
    logic        word_take;
    logic [9:0]  sum;
    logic [31:0] extract_data;

    bit_window_extract u_extract (
        .cur_word (cur_q),
        .nxt_word (nxt_q),
        .ptr      (ptr_q),
        .rd_len   (rd_len),
        .data     (extract_data)
    );

    // Handshake and occupancy signals derived purely from registered state and the request.
    always_comb begin
        bits_avail = 11'd0;
        if (cur_v_q) begin
            bits_avail = 11'd512 - {2'b00, ptr_q};
        end
        if (nxt_v_q) begin
            bits_avail = bits_avail + 11'd512;
        end
        word_ready = !nxt_v_q;
        len_ok     = rd_len_legal(rd_len);
        rd_ready   = rd_req && len_ok && ({5'b00000, rd_len} <= bits_avail);
        word_take  = word_valid && word_ready;
        sum        = {1'b0, ptr_q} + {4'b0000, rd_len};
    end

    // Next-state: consume/promote on an accepted read first, then place any incoming word.
    always_comb begin
        cur_d       = cur_q;
        nxt_d       = nxt_q;
        cur_v_d     = cur_v_q;
        nxt_v_d     = nxt_v_q;
        ptr_d       = ptr_q;
        bit_count_d = bit_count_q;
        rd_valid_d  = rd_ready;
        rd_err_d    = rd_req && !len_ok;
        rd_data_d   = rd_data_q;

        if (rd_ready) begin
            rd_data_d   = extract_data;
            bit_count_d = bit_count_q + 32'(rd_len);
            ptr_d       = sum[8:0];
            if (sum[9]) begin
                cur_d   = nxt_q;
                cur_v_d = nxt_v_q;
                nxt_v_d = 1'b0;
            end
        end

        if (word_take) begin
            if (!cur_v_d) begin
                cur_d   = word_data;
                cur_v_d = 1'b1;
            end else begin
                nxt_d   = word_data;
                nxt_v_d = 1'b1;
            end
        end
    end

    // State register; reset drops all buffered words and any pending result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_q       <= '0;
            nxt_q       <= '0;
            cur_v_q     <= 1'b0;
            nxt_v_q     <= 1'b0;
            ptr_q       <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_err_q    <= 1'b0;
            bit_count_q <= '0;
        end else begin
            cur_q       <= cur_d;
            nxt_q       <= nxt_d;
            cur_v_q     <= cur_v_d;
            nxt_v_q     <= nxt_v_d;
            ptr_q       <= ptr_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            rd_err_q    <= rd_err_d;
            bit_count_q <= bit_count_d;
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign rd_err    = rd_err_q;
    assign bit_count = bit_count_q;

endmodule

// File: tb/tb_bitstream_bit_reader.sv
// Directed bench for bitstream_bit_reader: a vector table for the basic read
// path plus hand-written sequences for straddling, starvation, promotion and reset.
module tb_bitstream_bit_reader;
    import lidar_bitstream_pkg::*;

    logic        clk;
    logic        reset;
    logic        word_valid;
    logic [511:0] word_data;
    logic        word_ready;
    logic        rd_req;
    logic [5:0]  rd_len;
    logic        rd_ready;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_err;
    logic [10:0] bits_avail;
    logic [31:0] bit_count;

    int n_cmp  = 0;
    int n_fail = 0;

    bs_word_t words [4];

    typedef struct {
        logic        push;
        logic [1:0]  widx;
        logic        req;
        logic [5:0]  len;
        logic        exp_rdy;
        logic        exp_wrdy;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_err;
        logic [10:0] exp_avail;
        logic [31:0] exp_count;
    } vec_t;

    vec_t vecs [6];

    bitstream_bit_reader dut (
        .clk        (clk),
        .reset      (reset),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_ready (word_ready),
        .rd_req     (rd_req),
        .rd_len     (rd_len),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_err     (rd_err),
        .bits_avail (bits_avail),
        .bit_count  (bit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, sample handshakes at negedge, return #1 after posedge.
    task automatic run_cycle(input logic push, input bs_word_t w, input logic req,
                             input logic [5:0] len, output logic pre_rdy, output logic pre_wrdy);
        word_valid = push;
        word_data  = w;
        rd_req     = req;
        rd_len     = len;
        @(negedge clk);
        pre_rdy  = rd_ready;
        pre_wrdy = word_ready;
        @(posedge clk);
        #1;
        word_valid = 1'b0;
        rd_req     = 1'b0;
        rd_len     = 6'd0;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        word_valid = 1'b0;
        word_data  = '0;
        rd_req     = 1'b0;
        rd_len     = 6'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Read n bits known to be zero in the stream, in chunks of up to 32.
    task automatic consume(input int n);
        int   left;
        logic r, wr;
        logic [5:0] l;
        left = n;
        while (left > 0) begin
            l = (left >= 32) ? 6'd32 : 6'(left);
            run_cycle(1'b0, '0, 1'b1, l, r, wr);
            check("consume_rdy", {31'd0, r}, 32'd1);
            check("consume_valid", {31'd0, rd_valid}, 32'd1);
            check("consume_data", rd_data, 32'd0);
            left -= int'(l);
        end
    endtask

    task automatic applyStimulus();
        logic r, wr;

        // Reset state
        do_reset();
        check("rst_word_ready", {31'd0, word_ready}, 32'd1);
        check("rst_bits_avail", {21'd0, bits_avail}, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_rd_err", {31'd0, rd_err}, 32'd0);
        check("rst_bit_count", bit_count, 32'd0);
        check("rst_rd_ready", {31'd0, rd_ready}, 32'd0);

        // Vector table: first word, byte reads, illegal lengths, second word load
        for (int i = 0; i < 6; i++) begin
            run_cycle(vecs[i].push, words[vecs[i].widx], vecs[i].req, vecs[i].len, r, wr);
            check($sformatf("v%0d_rd_ready", i), {31'd0, r}, {31'd0, vecs[i].exp_rdy});
            check($sformatf("v%0d_word_ready", i), {31'd0, wr}, {31'd0, vecs[i].exp_wrdy});
            check($sformatf("v%0d_rd_valid", i), {31'd0, rd_valid}, {31'd0, vecs[i].exp_valid});
            check($sformatf("v%0d_rd_data", i), rd_data, vecs[i].exp_data);
            check($sformatf("v%0d_rd_err", i), {31'd0, rd_err}, {31'd0, vecs[i].exp_err});
            check($sformatf("v%0d_bits_avail", i), {21'd0, bits_avail}, {21'd0, vecs[i].exp_avail});
            check($sformatf("v%0d_bit_count", i), bit_count, vecs[i].exp_count);
        end

        // Straddling read: load W1, advance to ptr 496, read across the boundary
        run_cycle(1'b1, words[1], 1'b0, 6'd0, r, wr);
        check("str_load_avail", {21'd0, bits_avail}, 32'd992);
        consume(464);
        check("str_pre_count", bit_count, 32'd496);
        run_cycle(1'b0, '0, 1'b1, 6'd32, r, wr);
        check("str_rdy", {31'd0, r}, 32'd1);
        check("str_wrdy_before", {31'd0, wr}, 32'd0);
        check("str_data", rd_data, 32'hABCD1234);
        check("str_avail", {21'd0, bits_avail}, 32'd496);
        check("str_wrdy_after", {31'd0, word_ready}, 32'd1);
        check("str_count", bit_count, 32'd528);
        run_cycle(1'b0, '0, 1'b1, 6'd32, r, wr);
        check("str_next_data", rd_data, 32'hDEADBEEF);
        check("str_next_avail", {21'd0, bits_avail}, 32'd464);

        // Starvation: 12 bits left, 16 requested, then a second word arrives
        do_reset();
        run_cycle(1'b1, words[2], 1'b0, 6'd0, r, wr);
        run_cycle(1'b0, '0, 1'b1, 6'd32, r, wr);
        check("stv_first_data", rd_data, 32'h80000001);
        consume(468);
        check("stv_avail", {21'd0, bits_avail}, 32'd12);
        for (int k = 0; k < 2; k++) begin
            run_cycle(1'b0, '0, 1'b1, 6'd16, r, wr);
            check("stv_rdy", {31'd0, r}, 32'd0);
            check("stv_valid", {31'd0, rd_valid}, 32'd0);
            check("stv_err", {31'd0, rd_err}, 32'd0);
        end
        run_cycle(1'b1, words[3], 1'b1, 6'd16, r, wr);
        check("stv_load_rdy", {31'd0, r}, 32'd0);
        check("stv_load_wrdy", {31'd0, wr}, 32'd1);
        check("stv_load_avail", {21'd0, bits_avail}, 32'd524);
        run_cycle(1'b0, '0, 1'b1, 6'd16, r, wr);
        check("stv_acc_rdy", {31'd0, r}, 32'd1);
        check("stv_acc_data", rd_data, 32'h0000ABC9);
        check("stv_acc_avail", {21'd0, bits_avail}, 32'd508);
        check("stv_acc_count", bit_count, 32'd516);

        // Promotion with both slots full: held word enters only after nxt frees
        run_cycle(1'b1, words[1], 1'b0, 6'd0, r, wr);
        check("pro_fill_avail", {21'd0, bits_avail}, 32'd1020);
        consume(476);
        run_cycle(1'b1, words[0], 1'b1, 6'd32, r, wr);
        check("pro_rdy", {31'd0, r}, 32'd1);
        check("pro_wrdy_before", {31'd0, wr}, 32'd0);
        check("pro_data", rd_data, 32'h13579BDF);
        check("pro_avail", {21'd0, bits_avail}, 32'd512);
        check("pro_wrdy_after", {31'd0, word_ready}, 32'd1);
        check("pro_count", bit_count, 32'd1024);
        run_cycle(1'b1, words[0], 1'b0, 6'd0, r, wr);
        check("pro_load_avail", {21'd0, bits_avail}, 32'd1024);
        check("pro_load_wrdy", {31'd0, word_ready}, 32'd0);
        run_cycle(1'b0, '0, 1'b1, 6'd16, r, wr);
        check("pro_next_data", rd_data, 32'h00001234);

        // Exact drain of cur with no nxt while a word arrives in the same cycle
        do_reset();
        run_cycle(1'b1, words[2], 1'b0, 6'd0, r, wr);
        run_cycle(1'b0, '0, 1'b1, 6'd32, r, wr);
        consume(448);
        run_cycle(1'b1, words[1], 1'b1, 6'd32, r, wr);
        check("drn_rdy", {31'd0, r}, 32'd1);
        check("drn_wrdy", {31'd0, wr}, 32'd1);
        check("drn_data", rd_data, 32'h00000ABC);
        check("drn_avail", {21'd0, bits_avail}, 32'd512);
        check("drn_count", bit_count, 32'd512);
        run_cycle(1'b0, '0, 1'b1, 6'd16, r, wr);
        check("drn_next_data", rd_data, 32'h00001234);
        check("drn_next_avail", {21'd0, bits_avail}, 32'd496);

        // Reset arriving with an acceptable read pending
        rd_req = 1'b1;
        rd_len = 6'd8;
        @(negedge clk);
        check("mid_rdy_pending", {31'd0, rd_ready}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        rd_len = 6'd0;
        check("mid_valid", {31'd0, rd_valid}, 32'd0);
        check("mid_avail", {21'd0, bits_avail}, 32'd0);
        check("mid_count", bit_count, 32'd0);
        check("mid_wrdy", {31'd0, word_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("mid_valid_after", {31'd0, rd_valid}, 32'd0);
    endtask

    task automatic checkOutput();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    endtask

    initial begin
        reset      = 1'b1;
        word_valid = 1'b0;
        word_data  = '0;
        rd_req     = 1'b0;
        rd_len     = 6'd0;

        words[0] = '0; words[0][511:480] = 32'hA5C3F00F; words[0][15:0]  = 16'hABCD;
        words[1] = '0; words[1][511:496] = 16'h1234;     words[1][495:464] = 32'hDEADBEEF;
        words[2] = '0; words[2][511:480] = 32'h80000001; words[2][11:0]  = 12'hABC;
        words[3] = '0; words[3][511:508] = 4'h9;         words[3][31:0]  = 32'h13579BDF;

        //           push  widx  req   len    rdy   wrdy  valid data           err   avail    count
        vecs[0] = '{1'b1, 2'd0, 1'b0, 6'd0,  1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0, 11'd512, 32'd0};
        vecs[1] = '{1'b0, 2'd0, 1'b1, 6'd8,  1'b1, 1'b1, 1'b1, 32'h000000A5, 1'b0, 11'd504, 32'd8};
        vecs[2] = '{1'b0, 2'd0, 1'b1, 6'd8,  1'b1, 1'b1, 1'b1, 32'h000000C3, 1'b0, 11'd496, 32'd16};
        vecs[3] = '{1'b0, 2'd0, 1'b1, 6'd0,  1'b0, 1'b1, 1'b0, 32'h000000C3, 1'b1, 11'd496, 32'd16};
        vecs[4] = '{1'b0, 2'd0, 1'b1, 6'd33, 1'b0, 1'b1, 1'b0, 32'h000000C3, 1'b1, 11'd496, 32'd16};
        vecs[5] = '{1'b0, 2'd0, 1'b1, 6'd16, 1'b1, 1'b1, 1'b1, 32'h0000F00F, 1'b0, 11'd480, 32'd32};

        applyStimulus();
        checkOutput();
        $finish;
    end

endmodule
